// File: rtl/mpi_stream_pkg.sv
// Shared definitions for the MPI stream datapath: word width, AND-identity pad
// value and the operand gatherer's state type.
package mpi_stream_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] PAD_AND = 16'hFFFF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } gather_state_t;

endpackage

// File: rtl/operand_gatherer.sv
// Packs a serial stream of 16-bit operands into n-slot vectors for the reduction
// trees, producing the per-slot select mask and padding slots a short group leaves empty.
module operand_gatherer
    import mpi_stream_pkg::*;
#(
    parameter int unsigned       n   = 4,
    parameter logic [WORD_W-1:0] PAD = PAD_AND
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   idata,
    input  logic                ivalid,
    output logic                iready,
    input  logic                istart,
    input  logic                ilast,
    output logic [WORD_W*n-1:0] odata,
    output logic [n-1:0]        osel,
    output logic                ovalid,
    input  logic                oready,
    output logic                ostart,
    output logic                olast,
    output logic                oerr
);

    localparam int unsigned       DATA_W    = WORD_W * n;
    localparam int unsigned       CNT_W     = $clog2(n);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(n - 1);
    localparam logic [DATA_W-1:0] PAD_VEC   = {n{PAD}};

    gather_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic [n-1:0]      osel_q, osel_d;
    logic              ovalid_q, ovalid_d;
    logic              ostart_q, ostart_d;
    logic              olast_q, olast_d;
    logic              oerr_q, oerr_d;
    // Remembers whether the most recent vector ended its group, so the next
    // group must open with istart.
    logic              closed_last_q, closed_last_d;

    logic in_xfer;
    logic out_xfer;

    assign iready   = (state_q == COLLECT) & ~reset;
    assign in_xfer  = ivalid & iready;
    assign out_xfer = ovalid_q & oready & ~reset;

    // Next-state: slot fill and vector close in COLLECT, release in HOLD.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        odata_d       = odata_q;
        osel_d        = osel_q;
        ovalid_d      = ovalid_q;
        ostart_d      = ostart_q;
        olast_d       = olast_q;
        oerr_d        = oerr_q;
        closed_last_d = closed_last_q;

        if (in_xfer) begin
            for (int unsigned k = 0; k < n; k++) begin
                if (count_q == CNT_W'(k)) begin
                    odata_d[WORD_W*(n-k)-1 -: WORD_W] = idata;
                    osel_d[n-1-k]                     = 1'b1;
                end
            end

            if (count_q == '0) begin
                ostart_d = istart;
                if (!istart && closed_last_q) begin
                    oerr_d = 1'b1;
                end
            end else if (istart) begin
                oerr_d = 1'b1;
            end

            if (ilast || (count_q == LAST_SLOT)) begin
                olast_d       = ilast;
                closed_last_d = ilast;
                ovalid_d      = 1'b1;
                state_d       = HOLD;
                count_d       = '0;
            end else begin
                count_d = CNT_W'(count_q + 1'b1);
            end
        end

        if (out_xfer) begin
            ovalid_d = 1'b0;
            odata_d  = PAD_VEC;
            osel_d   = '0;
            state_d  = COLLECT;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q       <= COLLECT;
            count_q       <= '0;
            odata_q       <= PAD_VEC;
            osel_q        <= '0;
            ovalid_q      <= 1'b0;
            ostart_q      <= 1'b0;
            olast_q       <= 1'b0;
            oerr_q        <= 1'b0;
            closed_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            odata_q       <= odata_d;
            osel_q        <= osel_d;
            ovalid_q      <= ovalid_d;
            ostart_q      <= ostart_d;
            olast_q       <= olast_d;
            oerr_q        <= oerr_d;
            closed_last_q <= closed_last_d;
        end
    end

    assign odata  = odata_q;
    assign osel   = osel_q;
    assign ovalid = ovalid_q;
    assign ostart = ostart_q;
    assign olast  = olast_q;
    assign oerr   = oerr_q;

endmodule

// File: tb/tb_operand_gatherer.sv
// Bench for operand_gatherer: directed scenarios followed by random groups, all
// checked every cycle against a queue-based model of the gathering rules.
module tb_operand_gatherer;
    import mpi_stream_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = WORD_W * N;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   idata = '0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic          istart = 1'b0;
    logic          ilast = 1'b0;
    logic [DW-1:0] odata;
    logic [N-1:0]  osel;
    logic          ovalid;
    logic          oready = 1'b0;
    logic          ostart;
    logic          olast;
    logic          oerr;

    int checks   = 0;
    int failures = 0;

    operand_gatherer #(.n(N), .PAD(16'hFFFF)) dut (
        .aclk  (aclk),
        .reset (reset),
        .idata (idata),
        .ivalid(ivalid),
        .iready(iready),
        .istart(istart),
        .ilast (ilast),
        .odata (odata),
        .osel  (osel),
        .ovalid(ovalid),
        .oready(oready),
        .ostart(ostart),
        .olast (olast),
        .oerr  (oerr)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [N-1:0]  sel;
        logic          start;
        logic          last;
    } vec_t;

    // Model state: words of the open group chunk, vectors awaiting hand-off.
    logic [15:0] cur_words[$];
    logic        cur_start = 1'b0;
    vec_t        exp_q[$];
    logic        exp_err   = 1'b0;
    logic        prev_last = 1'b0;

    function automatic vec_t build(input logic [15:0] words[$], input logic s, input logic l);
        vec_t v;
        v.data  = {N{16'hFFFF}};
        v.sel   = '0;
        v.start = s;
        v.last  = l;
        foreach (words[k]) begin
            v.data[DW-1-16*k -: 16] = words[k];
            v.sel[N-1-k]            = 1'b1;
        end
        return v;
    endfunction

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare every output against the model, then
    // advance the model by whatever transfers the rules say occur at this edge.
    task automatic step(input logic v, input logic [15:0] d, input logic s, input logic l,
                        input logic ordy, input logic rst, output logic acc);
        vec_t e;
        logic holding;
        @(negedge aclk);
        ivalid = v; idata = d; istart = s; ilast = l; oready = ordy; reset = rst;
        #1;
        holding = (exp_q.size() != 0);
        e = holding ? exp_q[0] : build(cur_words, cur_start, 1'b0);
        chk1("ovalid", ovalid, holding);
        chk1("iready", iready, !holding && !rst);
        chkw("odata", odata, e.data);
        chkw("osel", DW'(osel), DW'(e.sel));
        if (holding) begin
            chk1("ostart", ostart, e.start);
            chk1("olast", olast, e.last);
        end
        chk1("oerr", oerr, exp_err);

        acc = v && !holding && !rst;
        if (rst) begin
            cur_words.delete();
            exp_q.delete();
            exp_err   = 1'b0;
            prev_last = 1'b0;
            cur_start = 1'b0;
        end else if (holding && ordy) begin
            void'(exp_q.pop_front());
        end else if (acc) begin
            if (s && cur_words.size() > 0) exp_err = 1'b1;
            if (!s && cur_words.size() == 0 && prev_last) exp_err = 1'b1;
            if (cur_words.size() == 0) cur_start = s;
            cur_words.push_back(d);
            if (l || cur_words.size() == N) begin
                exp_q.push_back(build(cur_words, cur_start, l));
                prev_last = l;
                cur_words.delete();
            end
        end
    endtask

    // Offer one word until it is taken; rnd_ordy randomises oready per cycle.
    task automatic send(input logic [15:0] d, input logic s, input logic l, input logic rnd_ordy);
        logic acc;
        logic ordy;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            ordy = rnd_ordy ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b1, d, s, l, ordy, 1'b0, acc);
        end
        chk1("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int t = 0; t < cycles; t++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   len;

        // Reset state.
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        idle(1);

        // Full four-word group.
        send(16'h1111, 1'b1, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h4444, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Short group padded, and back-to-back next group.
        send(16'hAAAA, 1'b1, 1'b0, 1'b0);
        send(16'h5555, 1'b0, 1'b1, 1'b0);
        send(16'hBBBB, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Six-word group spans two vectors.
        for (int i = 1; i <= 6; i++) send(16'(i), i == 1, i == 6, 1'b0);
        idle(2);

        // Downstream stall while upstream holds a word.
        send(16'hC001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, acc);
            chk1("stall_no_accept", acc, 1'b0);
        end
        step(1'b1, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk1("xfer_cycle_no_accept", acc, 1'b0);
        step(1'b1, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk1("accept_after_xfer", acc, 1'b1);
        send(16'h8888, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Misplaced istart raises a sticky error.
        send(16'h0101, 1'b1, 1'b0, 1'b0);
        send(16'h0202, 1'b0, 1'b0, 1'b0);
        send(16'h0303, 1'b1, 1'b0, 1'b0);
        send(16'h0404, 1'b0, 1'b1, 1'b0);
        idle(1);
        send(16'h0505, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk1("oerr_sticky", oerr, 1'b1);

        // Reset mid-group discards partial words and clears the error.
        send(16'hDEAD, 1'b1, 1'b0, 1'b0);
        send(16'hBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        idle(1);
        chk1("oerr_after_reset", oerr, 1'b0);
        send(16'hF00D, 1'b1, 1'b0, 1'b0);
        send(16'hCAFE, 1'b0, 1'b0, 1'b0);
        send(16'h1234, 1'b0, 1'b0, 1'b0);
        send(16'h5678, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Random groups with idle gaps, backpressure and occasional protocol slips.
        for (int g = 0; g < 250; g++) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1'b0, 16'($urandom), 1'b0, 1'b0, $urandom_range(0, 1) != 0, 1'b0, acc);
                end
                send(16'($urandom), (i == 0) ^ ($urandom_range(0, 19) == 0),
                     i == len - 1, 1'b1);
            end
            if ($urandom_range(0, 49) == 0) begin
                step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
